// File: rtl/noc_pkg.sv
// noc_pkg: types shared by the NoC node-side blocks.
//   noc_flit_t  - flit with header/tail markers and payload
//   arb_state_t - packet-lock state of the injection arbiter
`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif

package noc_pkg;

    typedef struct packed {
        logic                       is_header;
        logic                       is_tail;
        logic [`Noc_Data_Width-1:0] data;
    } noc_flit_t;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/noc_rr_picker.sv
// noc_rr_picker: combinational round-robin pick.
//   req_i - request vector
//   ptr_i - highest-priority index; scan runs upward from here and wraps
//   gnt_o - one-hot grant
//   idx_o - index of the granted requester (0 when none)
//   any_o - at least one request present
module noc_rr_picker #(
    parameter int N     = 4,
    parameter int SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [SEL_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [SEL_W-1:0] idx_o,
    output logic             any_o
);

    logic             found;
    logic [SEL_W-1:0] j;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        j     = '0;
        for (int k = 0; k < N; k++) begin
            j = SEL_W'((int'(ptr_i) + k) % N);
            if (!found && req_i[j]) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = j;
            end
        end
    end

    assign any_o = found;

endmodule

// File: rtl/noc_inject_arbiter.sv
// noc_inject_arbiter: packet-granular round-robin arbiter feeding one NoC
// router injection port from NUM_SRC local sources.
//   noc_clk/noc_rst          - clock, async active-high reset
//   src_valid/ready/flit/... - per-source flit interfaces (flit i at [i*DATA_W +: DATA_W])
//   sender_*                 - registered flit interface to the router
//   arb_busy                 - a packet currently holds the port
//   arb_owner                - current or most recent owner
//   proto_err                - sticky: body flit offered in IDLE or header inside a packet
module noc_inject_arbiter
    import noc_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int DATA_W  = `Noc_Data_Width,
    parameter int SEL_W   = $clog2(NUM_SRC)
) (
    input  logic                      noc_clk,
    input  logic                      noc_rst,
    input  logic [NUM_SRC-1:0]        src_valid,
    output logic [NUM_SRC-1:0]        src_ready,
    input  logic [NUM_SRC*DATA_W-1:0] src_flit,
    input  logic [NUM_SRC-1:0]        src_is_header,
    input  logic [NUM_SRC-1:0]        src_is_tail,
    output logic                      sender_valid,
    input  logic                      sender_ready,
    output logic [DATA_W-1:0]         sender_flit,
    output logic                      sender_is_header,
    output logic                      sender_is_tail,
    output logic                      arb_busy,
    output logic [SEL_W-1:0]          arb_owner,
    output logic                      proto_err
);

    arb_state_t        state_q, state_d;
    logic [SEL_W-1:0]  owner_q, owner_d;
    logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic              sv_q, sv_d;
    logic [DATA_W-1:0] flit_q, flit_d;
    logic              hdr_q, hdr_d;
    logic              tail_q, tail_d;
    logic              perr_q, perr_d;

    logic [DATA_W-1:0]  flit_arr [NUM_SRC];
    logic [NUM_SRC-1:0] win_gnt;
    logic [SEL_W-1:0]   win_idx;
    logic               win_any;
    logic [SEL_W-1:0]   sel;
    logic               grant;
    logic               slot_free;
    logic               accept;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_unpack
        assign flit_arr[g] = src_flit[g*DATA_W +: DATA_W];
    end

    // Only headers compete; body flits never win an idle port.
    noc_rr_picker #(.N(NUM_SRC), .SEL_W(SEL_W)) u_pick (
        .req_i (src_valid & src_is_header),
        .ptr_i (rr_ptr_q),
        .gnt_o (win_gnt),
        .idx_o (win_idx),
        .any_o (win_any)
    );

    assign slot_free = !sv_q || sender_ready;
    assign sel       = (state_q == ARB_IDLE) ? win_idx : owner_q;
    assign grant     = (state_q == ARB_IDLE) ? win_any : 1'b1;

    // Ready is held low during reset so no source believes a flit was taken.
    always_comb begin
        src_ready = '0;
        if (grant && !noc_rst) src_ready[sel] = slot_free;
    end

    assign accept = src_ready[sel] && src_valid[sel];

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        sv_d     = sv_q;
        flit_d   = flit_q;
        hdr_d    = hdr_q;
        tail_d   = tail_q;
        perr_d   = perr_q;

        if (state_q == ARB_IDLE && |(src_valid & ~src_is_header)) perr_d = 1'b1;

        if (accept) begin
            sv_d   = 1'b1;
            flit_d = flit_arr[sel];
            hdr_d  = src_is_header[sel];
            tail_d = src_is_tail[sel];
            if (state_q == ARB_IDLE) begin
                owner_d  = sel;
                rr_ptr_d = (sel == SEL_W'(NUM_SRC-1)) ? '0 : sel + 1'b1;
                // A header that is also a tail is a complete packet: no lock.
                state_d  = src_is_tail[sel] ? ARB_IDLE : ARB_LOCKED;
            end else begin
                if (src_is_tail[sel])   state_d = ARB_IDLE;
                if (src_is_header[sel]) perr_d  = 1'b1;
            end
        end else if (sender_ready) begin
            sv_d = 1'b0;
        end
    end

    always_ff @(posedge noc_clk or posedge noc_rst) begin
        if (noc_rst) begin
            state_q  <= ARB_IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            sv_q     <= 1'b0;
            flit_q   <= '0;
            hdr_q    <= 1'b0;
            tail_q   <= 1'b0;
            perr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            sv_q     <= sv_d;
            flit_q   <= flit_d;
            hdr_q    <= hdr_d;
            tail_q   <= tail_d;
            perr_q   <= perr_d;
        end
    end

    assign sender_valid     = sv_q;
    assign sender_flit      = flit_q;
    assign sender_is_header = hdr_q;
    assign sender_is_tail   = tail_q;
    assign arb_busy         = (state_q == ARB_LOCKED);
    assign arb_owner        = owner_q;
    assign proto_err        = perr_q;

endmodule

// File: doc/noc_inject_arbiter.md
# noc_inject_arbiter

Packet-granular round-robin arbiter that lets NUM_SRC local requesters share one NoC router injection port. It sits between the node's traffic sources and the router's local input, using the same sender_* valid/ready flit interface. Once a header is granted, the owner keeps the port until its tail flit is accepted, so flits from different packets never interleave. A one-entry output register decouples the router's `sender_ready` from the source-side ready paths.

## Interface
Parameters:
- NUM_SRC, default 4: number of requesters, at least 2.
- DATA_W, default `Noc_Data_Width: flit payload width.
- SEL_W, default $clog2(NUM_SRC): owner index width.

Ports:
- noc_clk  in  1  clock; all logic rising-edge.
- noc_rst  in  1  reset, asynchronous, active-high.
- src_valid  in  NUM_SRC  per-source flit valid.
- src_ready  out  NUM_SRC  per-source accept.
- src_flit  in  NUM_SRC*DATA_W  flits; source i occupies bits [i*DATA_W +: DATA_W].
- src_is_header  in  NUM_SRC  per-source header marker.
- src_is_tail  in  NUM_SRC  per-source tail marker.
- sender_valid  out  1  flit to router valid.
- sender_ready  in  1  router accepts.
- sender_flit  out  DATA_W  flit to router.
- sender_is_header  out  1  header marker.
- sender_is_tail  out  1  tail marker.
- arb_busy  out  1  a packet is locked (state LOCKED).
- arb_owner  out  SEL_W  current or last owner index.
- proto_err  out  1  sticky protocol-error flag.

## Operation
- Transfer on any side happens when valid and ready are both high at the clock edge.
- slot_free = !sender_valid || sender_ready. A source flit can be accepted only when slot_free is high.
- State IDLE:
  - Candidates are sources with src_valid & src_is_header.
  - The winner is the first candidate at or after rr_ptr, scanning upward and wrapping.
  - src_ready[win] = slot_free; all other src_ready bits are 0.
  - On accept: owner <= win, rr_ptr <= (win+1) mod NUM_SRC.
  - Next state is LOCKED, unless the header also has is_tail set (single-flit packet), in which case the state stays IDLE.
- State LOCKED:
  - src_ready[owner] = slot_free, independent of src_valid. All other bits are 0.
  - Accepting a flit with is_tail set returns the state to IDLE.
  - A flit accepted with is_header set while LOCKED sets proto_err. The flit is still forwarded.
- In IDLE, a source that is valid with is_header=0 is never granted, and proto_err is set.
- Output register:
  - On accept, the flit and its markers are loaded and sender_valid <= 1.
  - When sender_ready is high and no new accept occurs, sender_valid <= 0.
  - While sender_valid=1 and sender_ready=0, the held flit is stable.
- proto_err clears only on reset.

## Timing
- Reset values: all outputs 0, rr_ptr=0, owner=0, state IDLE. Source 0 has first priority after reset.
- Latency: a flit accepted at edge T appears on sender_* during cycle T+1.
- Throughput: 1 flit per cycle while sender_ready is held high.
- Packet boundary: tail accepted at edge T, state is IDLE in cycle T+1, and the next header can be accepted at edge T+1. There is no bubble between packets.
- src_ready is combinational:
  - In IDLE it depends on src_valid, src_is_header and sender_ready.
  - In LOCKED it depends on sender_ready only.
  - Sources must not make src_valid depend on src_ready.
- Reset asserted mid-packet: the output register is cleared, lock and pointer are dropped, and the partial packet is lost. Sources must also be reset.
- A LOCKED owner that deasserts src_valid keeps the lock indefinitely. There is no timeout.

## Structure
- Shared package noc_pkg holds:
  - typedef noc_flit_t: struct {is_header, is_tail, data[`Noc_Data_Width-1:0]}.
  - enum arb_state_t {ARB_IDLE, ARB_LOCKED}.
- Sub-module noc_rr_picker: combinational request vector + pointer -> one-hot grant, index, any. It is reusable by the router's output-port allocators.
- The top level holds the FSM, rr_ptr, owner, the output register and proto_err.

## Test plan
- Single source: src0 sends a 3-flit packet (H, B, T) with sender_ready=1 -> three flits on sender_* in cycles T+1 to T+3, in order, with the header marker on the first and the tail marker on the last.
- Contention: all 4 sources present headers simultaneously after reset; each sends a 2-flit packet. Required results:
  - Grant order is 0, 1, 2, 3.
  - No interleaving of flits from different packets.
  - 8 consecutive sender_valid cycles.
- Backpressure: sender_ready=0 for 5 cycles mid-packet -> sender_flit is held stable, src_ready[owner]=0, and no flit is lost or duplicated.
- Single-flit packets: src1 and src2 each send H+T flits while the other sources are idle -> they alternate 1, 2, 1, 2 and arb_busy stays 0.
- Protocol error: src3 asserts valid with is_header=0 while in IDLE -> src_ready[3]=0, proto_err=1 the next cycle, and the flag is still 1 after 10 cycles.
- Reset mid-packet: assert noc_rst during the 2nd flit -> all outputs 0 immediately, and the first header after release is granted to src0.
